// File: rtl/secded16_decoder_pkg.sv
// ---------------------------------------------------------------------------
// secded_pkg
// Shared constants for the SECDED(16,11) decode engine.
//   - FSM state codes (3-bit, legacy-compatible encoding)
//   - 2-bit error flag values written alongside each decoded message
//   - Hamming bit positions that carry message bits d1..d11
// No ports (package).
// ---------------------------------------------------------------------------
package secded_pkg;

  // FSM state codes
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] CAP   = 3'd3;
  localparam logic [2:0] WR_LO = 3'd4;
  localparam logic [2:0] WR_HI = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  // Error flags; 2'b11 is never produced
  localparam logic [1:0] FLAG_NONE   = 2'b00;
  localparam logic [1:0] FLAG_SINGLE = 2'b01;
  localparam logic [1:0] FLAG_DOUBLE = 2'b10;

  localparam int NUM_DATA_BITS = 11;

  // Codeword position of message bit d(j+1). Positions 1,2,4,8 hold the
  // Hamming parity bits and position 0 holds overall parity p0.
  localparam int DATA_POS [NUM_DATA_BITS] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/secded16_decoder_if.sv
// ---------------------------------------------------------------------------
// secded16_decoder_if
// Byte-wide data-memory bus shared by the decode engine and the memory.
//   mem_addr    : byte address (ADDR_W bits)
//   mem_wr_en   : write strobe
//   mem_wr_data : write byte
//   mem_rd_data : read byte, valid the cycle after mem_addr (synchronous)
// Modports: master = decode engine, slave = memory.
// ---------------------------------------------------------------------------
interface secded16_decoder_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/secded16_decoder_correct.sv
// ---------------------------------------------------------------------------
// secded16_correct
// Combinational SECDED(16,11) check-and-correct for one codeword.
//   w    [15:0] : in  codeword (bit k = Hamming position k, bit 0 = p0)
//   data [10:0] : out corrected message d11..d1
//   flag [1:0]  : out 00 clean, 01 single error (corrected), 10 double error
// ---------------------------------------------------------------------------
module secded16_correct
  import secded_pkg::*;
(
  input  logic [15:0] w,
  output logic [10:0] data,
  output logic [1:0]  flag
);

  logic [3:0]               syndrome;
  logic                     parity;
  logic [NUM_DATA_BITS-1:0] raw_data;
  logic [NUM_DATA_BITS-1:0] data_flip;

  always_comb begin
    syndrome = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (w[k]) syndrome = syndrome ^ 4'(k);
    end
    parity = ^w;
    flag   = FLAG_NONE;
    if (parity)
      flag = FLAG_SINGLE;
    else if (syndrome != 4'd0)
      flag = FLAG_DOUBLE;
  end

  // Only a single error (odd overall parity) is corrected, and only when the
  // syndrome points at a message bit; a syndrome naming a parity position or
  // zero (p0 itself flipped) leaves the message untouched.
  for (genvar gi = 0; gi < NUM_DATA_BITS; gi++) begin : g_data
    assign raw_data[gi]  = w[DATA_POS[gi]];
    assign data_flip[gi] = parity && (syndrome == 4'(DATA_POS[gi]));
  end

  assign data = raw_data ^ data_flip;

endmodule

// File: rtl/secded16_decoder.sv
// ---------------------------------------------------------------------------
// secded16_decoder
// Second bus master on the data memory. On a start pulse it reads NUM_WORDS
// encoded 16-bit words (low byte first) from SRC_BASE, corrects each one and
// writes {flag, 3'b000, d11..d9} / d8..d1 back starting at DST_BASE.
// Five cycles per word; done rises one cycle after the last write.
//   clk    : in  system clock
//   reset  : in  asynchronous active-low reset
//   start  : in  one-cycle run request, honoured only in IDLE
//   done   : out high from run completion until the next accepted start
//   bus    : master side of the byte-wide memory bus
// ---------------------------------------------------------------------------
module secded16_decoder
  import secded_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 done,
  secded16_decoder_if.master   bus
);

  localparam int CNT_W = $clog2(NUM_WORDS) + 1;

  logic [2:0]        state_reg;
  logic [2:0]        state_next;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic [7:0]        lo_byte_reg;
  logic [7:0]        hi_byte_reg;
  logic              done_reg;

  logic [10:0]       data;
  logic [1:0]        flag;
  logic              last_word;
  logic [ADDR_W-1:0] word_off;

  assign last_word = (word_cnt_reg == CNT_W'(NUM_WORDS - 1));
  assign word_off  = ADDR_W'({word_cnt_reg, 1'b0});
  assign done      = done_reg;

  secded16_correct u_correct (
    .w    ({hi_byte_reg, lo_byte_reg}),
    .data (data),
    .flag (flag)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RD_LO;
      RD_LO:   state_next = RD_HI;
      RD_HI:   state_next = CAP;
      CAP:     state_next = WR_LO;
      WR_LO:   state_next = WR_HI;
      WR_HI:   state_next = last_word ? DONE : RD_LO;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      lo_byte_reg  <= 8'd0;
      hi_byte_reg  <= 8'd0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            word_cnt_reg <= '0;
            done_reg     <= 1'b0;
          end
        end
        // Memory read is synchronous: the byte addressed in the previous
        // state is on mem_rd_data now.
        RD_HI:   lo_byte_reg <= bus.mem_rd_data;
        CAP:     hi_byte_reg <= bus.mem_rd_data;
        WR_HI:   if (!last_word) word_cnt_reg <= word_cnt_reg + 1'b1;
        DONE:    done_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  // Bus outputs decode straight from state so an async reset releases the
  // write strobe immediately rather than at the next edge.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = 8'd0;
    case (state_reg)
      RD_LO: bus.mem_addr = ADDR_W'(SRC_BASE) + word_off;
      RD_HI: bus.mem_addr = ADDR_W'(SRC_BASE) + word_off + ADDR_W'(1);
      WR_LO: begin
        bus.mem_addr    = ADDR_W'(DST_BASE) + word_off;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = data[7:0];
      end
      WR_HI: begin
        bus.mem_addr    = ADDR_W'(DST_BASE) + word_off + ADDR_W'(1);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = {flag, 3'b000, data[10:8]};
      end
      default: ;
    endcase
  end

endmodule

// File: doc/secded16_decoder.md
Name: secded16_decoder

Overview:
- Hardware SECDED(16,11) decode engine; the stage directly downstream of the program-1 Hamming encoder.
- Reads 15 encoded 16-bit words from data memory bytes 30..59.
- Checks and corrects each word, then writes the 11-bit message plus a 2-bit error flag to bytes 0..29.
- Sits beside the data memory as a second bus master, started by a pulse and reporting completion on done.

Parameters:
NUM_WORDS, 15, number of encoded words processed per run
SRC_BASE, 30, byte address of first encoded word (low byte)
DST_BASE, 0, byte address of first decoded result (low byte)
ADDR_W, 8, memory byte-address width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; all state clears while low
start  input  1  one-cycle pulse; begins a run when idle
mem_addr  output  ADDR_W  byte address to data memory
mem_wr_en  output  1  write strobe for mem_wr_data at mem_addr
mem_wr_data  output  8  write byte
mem_rd_data  input  8  read byte; valid the cycle after mem_addr is presented (synchronous read)
done  output  1  high from run completion until next accepted start

Behaviour:
- Reset values: state IDLE, word counter 0, mem_addr 0, mem_wr_en 0, mem_wr_data 0, done 0. Reset mid-run aborts immediately; no partial write is completed.
- Word layout: encoded word W[15:0] = {mem[SRC_BASE+2i+1], mem[SRC_BASE+2i]}.
  - Bit k (1..15) is Hamming position k; bit 0 is overall parity p0.
  - Data d11..d5 = W[15:9], d4..d2 = W[7:5], d1 = W[3].
- Decode:
  - Syndrome S[3:0] = XOR of indices k where W[k]=1. Overall parity P = ^W.
  - S=0, P=0: no error, F=00.
  - P=1: single error, F=01. If S!=0, flip W[S] before data extraction; if S=0, p0 is in error and data is unchanged.
  - S!=0, P=0: double error, F=10; data extracted uncorrected.
  - F=11 is never produced.
- Output: mem[DST_BASE+2i+1] = {F[1:0], 3'b000, d11..d9}; mem[DST_BASE+2i] = d8..d1.
- FSM, states and transitions:
  - IDLE -> RD_LO when start=1.
  - RD_LO: present SRC_BASE+2i.
  - RD_HI: present SRC_BASE+2i+1; capture low byte.
  - CAP: capture high byte.
  - WR_LO: mem_wr_en=1, addr DST_BASE+2i.
  - WR_HI: mem_wr_en=1, addr DST_BASE+2i+1. Goes to DONE if i==NUM_WORDS-1, else increments i and goes to RD_LO.
  - DONE: done=1, -> IDLE next cycle. done stays high in IDLE until the next start.
- Timing: 5 cycles per word. With start sampled at edge 0, done rises at edge 5*NUM_WORDS+1 (76 for the default).
- Boundaries:
  - start while not IDLE/DONE-held is ignored.
  - start in IDLE with done=1 clears done on the same edge and begins a new run.
  - mem_wr_en is high only in WR_LO/WR_HI.
  - Counter width is $clog2(NUM_WORDS)+1; no wrap within a run.
  - Source and destination ranges must not overlap (integration rule, not checked).

Decomposition:
- Package secded_pkg:
  - state enum (IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE).
  - Flag constants FLAG_NONE=2'b00, FLAG_SINGLE=2'b01, FLAG_DOUBLE=2'b10.
  - Bit-position constants for parity and data positions.
- Sub-module secded16_correct: combinational. Input W[15:0]; outputs data[10:0] and flag[1:0]. Instantiated once by the FSM.

Test Plan:
- All-zero word 0x0000 in all 15 slots -> every output pair hi 0x00, lo 0x00; done at cycle 76.
- Clean 0xFFFF (data 0x7FF) -> hi 0x07, lo 0xFF.
- Single error at position 5: 0xFFDF -> corrected, hi 0x47, lo 0xFF.
- p0 error: 0xFFFE -> hi 0x47, lo 0xFF.
- Double error at positions 3 and 5: 0xFFD7 -> hi 0x87, lo 0xFC (uncorrected, F=10).
- Reset low at cycle 20 of a run -> mem_wr_en drops the same instant and done stays 0. A fresh start then processes all 15 words correctly. A start pulse mid-run has no effect on addresses or timing.
